// File: rtl/inst_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
//   INST_W / PC_W : instruction and PC widths
//   PC_STEP       : sequential fetch increment
//   INST_NOP      : value driven on out_inst when the queue is empty
//   ifq_entry_t   : one queue entry, {pc, inst}
//   align_pc      : forces a PC to word alignment
package inst_fetch_queue_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned PC_W   = 32;

  localparam logic [PC_W-1:0]   PC_STEP  = 32'd4;
  localparam logic [INST_W-1:0] INST_NOP = 32'h0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } ifq_entry_t;

  localparam int unsigned ENTRY_W = $bits(ifq_entry_t);

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// ifq_fifo: synchronous FIFO holding {pc, inst} entries for the fetch queue.
// Ports:
//   clk   in   clock, all updates on posedge
//   rst   in   synchronous active-high reset, empties the FIFO
//   flush in   synchronous flush, empties the FIFO; overrides push/pop
//   push  in   write wdata at the tail (ignored when full)
//   wdata in   entry to write
//   pop   in   discard the head entry (ignored when empty)
//   rdata out  head entry (combinational read of the head slot)
//   full  out  count == DEPTH
//   empty out  count == 0
module ifq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign w_do_push = push && !full && !flush;
  assign w_do_pop  = pop && !empty && !flush;
  assign rdata     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
    end
  end

  // Storage is not reset: an entry is only visible once pushed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: PC generator plus instruction prefetch queue.
// Drives imem_addr from the PC, captures {pc, imem_inst} into ifq_fifo and
// presents the head to decode over out_valid/out_ready. A redirect flushes the
// queue and reloads the PC.
// Optional feature: define IFQ_PERF_CNT_EN to add the perf_bubbles counter port.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   halt                stop fetching; queue keeps draining
//   redirect_valid/_pc  flush queue and load new (word-aligned) PC
//   imem_addr/imem_inst combinational instruction memory interface
//   out_valid/_ready    decode handshake; out_inst/out_pc are 0 when empty
//   perf_bubbles        cycles decode was ready but the queue was empty
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubbles
`endif
);

  logic [PC_W-1:0] r_pc;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  ifq_entry_t      w_wentry;
  ifq_entry_t      w_head;
  logic [ENTRY_W-1:0] w_rdata;

  assign imem_addr = r_pc;
  assign out_valid = !w_empty;

  // Full is taken from the registered count, so a same-cycle pop does not
  // open a slot for a push.
  assign w_push = !w_full && !halt && !redirect_valid;
  assign w_pop  = out_valid && out_ready;

  assign w_wentry.pc   = r_pc;
  assign w_wentry.inst = imem_inst;
  assign w_head        = ifq_entry_t'(w_rdata);

  assign out_inst = out_valid ? w_head.inst : INST_NOP;
  assign out_pc   = out_valid ? w_head.pc   : '0;

  ifq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (w_push),
    .wdata (w_wentry),
    .pop   (w_pop),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst)                 r_pc <= RESET_PC;
    else if (redirect_valid) r_pc <= align_pc(redirect_pc);
    else if (w_push)         r_pc <= r_pc + PC_STEP;
  end

`ifdef IFQ_PERF_CNT_EN
  logic [31:0] r_perf_bubbles;
  logic        w_bubble;

  assign w_bubble     = out_ready && !out_valid && !redirect_valid;
  assign perf_bubbles = r_perf_bubbles;

  always_ff @(posedge clk) begin
    if (rst)                                 r_perf_bubbles <= '0;
    else if (w_bubble && r_perf_bubbles != '1) r_perf_bubbles <= r_perf_bubbles + 32'd1;
  end
`endif

endmodule
